// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and width for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2
   } md_state_e;

   // Two's-complement magnitude when the operand is treated as negative.
   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring).
// Multiply: acc = {partial, multiplier}; adds opd to upper half when acc[0], shifts right.
// Divide:   acc = {remainder, dividend/quotient}; shifts left, trial-subtracts opd.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opd,
   output logic [2*XLEN-1:0] acc_nxt
);

   logic [XLEN:0]   x_op;
   logic [XLEN+1:0] res;

   // Single add/subtract plus the shift for either operation.
   always_comb begin
      x_op = is_div ? {acc[2*XLEN-1:XLEN], acc[XLEN-1]} : {1'b0, acc[2*XLEN-1:XLEN]};
      if (is_div) res = {1'b0, x_op} - {2'b00, opd};
      else        res = {1'b0, x_op} + {2'b00, opd};
      acc_nxt = acc;
      if (is_div) begin
         if (!res[XLEN+1]) acc_nxt = {res[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else              acc_nxt = {x_op[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         if (acc[0]) acc_nxt = {res[XLEN:0], acc[XLEN-1:1]};
         else        acc_nxt = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with CPU stall handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting; mthi/mtlo write directly, md ops latch operands
//   ST_CALC  | 32 radix-2 steps, counter 0..31, stall high
//   ST_FIXUP | sign correction, HI/LO load on exit edge, done pulse
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            stall,
   output logic            done
);

   md_state_e         state_q, state_d;
   md_op_e            op_q, op_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic              stall_c, is_div, sgn_op, sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b, quo_fix, rem_fix;
   logic [2*XLEN-1:0] prod_fix;

   assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

   muldiv_step u_step (
      .is_div  (is_div),
      .acc     (acc_q),
      .opd     (opd_q),
      .acc_nxt (step_acc)
   );

   // Sign correction of the finished accumulator.
   always_comb begin
      prod_fix = acc_q;
      quo_fix  = acc_q[XLEN-1:0];
      rem_fix  = acc_q[2*XLEN-1:XLEN];
      if (op_q == MD_MULT && neg_res_q) prod_fix = ~acc_q + 1'b1;
      if (op_q == MD_DIV) begin
         if (neg_res_q) quo_fix = ~acc_q[XLEN-1:0] + 1'b1;
         if (neg_rem_q) rem_fix = ~acc_q[2*XLEN-1:XLEN] + 1'b1;
      end
   end

   // Next-state, datapath loads and handshake outputs.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opd_d     = opd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall_c   = 1'b0;
      done      = 1'b0;
      sgn_op    = (op == MD_MULT) || (op == MD_DIV);
      sa        = sgn_op & a[XLEN-1];
      sb        = sgn_op & b[XLEN-1];
      mag_a     = abs_val(a, sa);
      mag_b     = abs_val(b, sb);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     stall_c   = 1'b1;
                     state_d   = ST_CALC;
                     op_d      = md_op_e'(op);
                     cnt_d     = 5'd0;
                     acc_d     = {{XLEN{1'b0}}, mag_b};
                     opd_d     = mag_a;
                     neg_res_d = sa ^ sb;
                     neg_rem_d = sa;
                  end
                  MD_DIV, MD_DIVU: begin
                     stall_c   = 1'b1;
                     state_d   = ST_CALC;
                     op_d      = md_op_e'(op);
                     cnt_d     = 5'd0;
                     acc_d     = {{XLEN{1'b0}}, mag_a};
                     opd_d     = mag_b;
                     neg_res_d = sa ^ sb;
                     neg_rem_d = sa;
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_CALC: begin
            stall_c = 1'b1;
            acc_d   = step_acc;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            done    = 1'b1;
            state_d = ST_IDLE;
            if (is_div) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*XLEN-1:XLEN];
               lo_d = prod_fix[XLEN-1:0];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stall is forced low while reset is asserted so the CPU is never held by a dead unit.
   assign stall = rst_n & stall_c;
   assign hi    = hi_q;
   assign lo    = lo_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= MD_NONE;
         cnt_q     <= 5'd0;
         acc_q     <= '0;
         opd_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opd_q     <= opd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue, compared at completion.
module tb_muldiv_unit;

   localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                          OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5,
                          OP_MTLO = 3'd6, OP_RSVD = 3'd7;

   logic        clk, rst_n, start, stall, done;
   logic [2:0]  op;
   logic [31:0] a, b, hi, lo;

   int checks, errors;
   logic [63:0] sb_q[$];

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .stall (stall),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result {hi, lo} computed with native arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      int sx, sy, q, r;
      logic [31:0] qq, rr;
      case (o)
         OP_MULTU: p = {32'd0, x} * {32'd0, y};
         OP_MULT:  p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
         OP_DIVU: begin
            if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
            else            p = {x % y, x / y};
         end
         OP_DIV: begin
            if (y == 32'd0)                                 p = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
            else begin
               sx = x; sy = y;
               q = sx / sy; r = sx % sy;
               qq = q; rr = r;
               p = {rr, qq};
            end
         end
         default: p = 64'd0;
      endcase
      return p;
   endfunction

   // Issue one md op as the CPU would, hold it while stalled, then check everything.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
      logic [31:0] hi0, lo0;
      logic [63:0] exp;
      int stall_cnt;
      bit seen, hold_ok;
      @(negedge clk);
      hi0 = hi; lo0 = lo;
      start = 1'b1; op = o; a = x; b = y;
      sb_q.push_back(model(o, x, y));
      stall_cnt = 0; seen = 0; hold_ok = 1;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
         #1;
         if (stall) stall_cnt++;
         if (done) seen = 1;
         if (hi !== hi0 || lo !== lo0) hold_ok = 0;
         if (!seen) @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done not seen within 40 cycles, required done=1", nm);
         start = 1'b0; op = OP_NONE;
         void'(sb_q.pop_front());
         return;
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      start = 1'b0; op = OP_NONE;
      checks++;
      if ({hi, lo} !== exp) begin
         errors++;
         $display("FAIL %s_result: got hi=%08h lo=%08h, required hi=%08h lo=%08h", nm, hi, lo, exp[63:32], exp[31:0]);
      end
      checks++;
      if (stall_cnt != 33) begin
         errors++;
         $display("FAIL %s_stall_cycles: got %0d, required 33", nm, stall_cnt);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_width: done=%b after fixup exit, required 0", nm, done);
      end
      checks++;
      if (!hold_ok) begin
         errors++;
         $display("FAIL %s_hilo_hold: hi/lo changed before fixup exit, required %08h/%08h", nm, hi0, lo0);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; op = OP_MULT; a = 32'h5; b = 32'h7;
      #12;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: hi=%08h lo=%08h stall=%b done=%b, required 0/0/0/0", hi, lo, stall, done);
      end
      start = 1'b0; op = OP_NONE;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_multu_max;
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
   endtask

   task automatic test_signed;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg");
   endtask

   task automatic test_div_edge;
      run_op(OP_DIVU, 32'd100, 32'd0, "divu_zero");
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(OP_DIV,  32'hFFFF_FFF0, 32'd0, "div_zero_neg");
   endtask

   task automatic test_mthi_mtlo;
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b, required 0", stall); end
      @(posedge clk); #1;
      checks++;
      if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_value: got %08h, required 12345678", hi); end
      op = OP_MTLO; a = 32'h9ABC_DEF0;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b, required 0", stall); end
      @(posedge clk); #1;
      checks++;
      if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mtlo_value: got hi=%08h lo=%08h, required 12345678/9abcdef0", hi, lo);
      end
      start = 1'b0; op = OP_NONE;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'd5678;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1; rst_n = 1'b0; start = 1'b0; op = OP_NONE;
      #1;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: hi=%08h lo=%08h stall=%b done=%b, required 0/0/0/0", hi, lo, stall, done);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (stall !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_idle: stall=%b done=%b hi=%08h lo=%08h, required 0/0/0/0", stall, done, hi, lo);
      end
      run_op(OP_DIVU, 32'd9, 32'd4, "divu_after_reset");
   endtask

   task automatic test_held_start;
      bit quiet;
      run_op(OP_MULT, 32'd300, 32'hFFFF_FF00, "mult_held");
      quiet = 1;
      repeat (40) begin
         @(negedge clk);
         if (stall !== 1'b0 || done !== 1'b0) quiet = 0;
      end
      checks++;
      if (!quiet) begin errors++; $display("FAIL held_start_restart: unit active after fixup, required idle"); end
   endtask

   task automatic test_none;
      logic [31:0] hi0, lo0;
      bit ok;
      hi0 = hi; lo0 = lo; ok = 1;
      @(negedge clk);
      start = 1'b1; op = OP_NONE; a = 32'hDEAD_BEEF;
      repeat (3) begin
         #1; if (stall !== 1'b0) ok = 0;
         @(negedge clk);
      end
      op = OP_RSVD;
      repeat (3) begin
         #1; if (stall !== 1'b0) ok = 0;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (!ok || hi !== hi0 || lo !== lo0) begin
         errors++;
         $display("FAIL none_op: stall_ok=%0d hi=%08h lo=%08h, required 1 %08h %08h", ok, hi, lo, hi0, lo0);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 10; i++) begin
         o = 3'($urandom_range(1, 4));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         run_op(o, x, y, "random");
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      start = 1'b0; op = OP_NONE; a = '0; b = '0; rst_n = 1'b0;
      test_reset();
      test_multu_max();
      test_signed();
      test_div_edge();
      test_mthi_mtlo();
      test_reset_mid();
      test_held_start();
      test_none();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: current instruction is a HI/LO operation; held high by the CPU while stall is high.
REQ-004 SHALL have port op, input, 3: operation code. 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-005 SHALL have port a, input, 32: rs operand.
REQ-006 SHALL have port b, input, 32: rt operand.
REQ-007 SHALL have port hi, output, 32: HI register, read directly by mfhi.
REQ-008 SHALL have port lo, output, 32: LO register, read directly by mflo.
REQ-009 SHALL have port stall, output, 1: combinational; holds the PC and instruction.
REQ-010 SHALL have port done, output, 1: one-cycle pulse, high in FIXUP.

Function
REQ-011 SHALL implement states IDLE, CALC and FIXUP.
REQ-012 In IDLE, start with op in {mult, multu, div, divu} SHALL latch a, b, op and the operand signs, then go to CALC with iteration counter = 0.
REQ-013 CALC SHALL perform one radix-2 step per cycle for exactly 32 cycles (counter 0..31), then go to FIXUP.
REQ-014 Multiply SHALL use shift-add on 32-bit magnitudes into a 64-bit accumulator; signed mult SHALL take the magnitudes of a and b.
REQ-015 Divide SHALL use restoring division on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
REQ-016 FIXUP SHALL apply sign correction and load HI/LO at the FIXUP-exit edge, then return to IDLE.
REQ-017 Multiply SHALL give HI = product[63:32] and LO = product[31:0]; signed mult SHALL negate the 64-bit product when sign(a) XOR sign(b).
REQ-018 Divide SHALL give LO = quotient and HI = remainder; signed div SHALL negate the quotient when signs differ, and the remainder SHALL take the sign of a.
REQ-019 Division by zero SHALL be deterministic: magnitude quotient 0xFFFFFFFF, remainder = |a|, then normal sign fixup (divu: LO = 0xFFFFFFFF, HI = a).
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-021 stall SHALL equal (state == IDLE AND start AND op is mult/multu/div/divu) OR (state == CALC); stall SHALL be 0 in FIXUP.
REQ-022 The CPU advances at the FIXUP-exit edge; total occupancy is 34 cycles with stall high for 33 of them.
REQ-023 start SHALL be ignored in CALC and FIXUP; the still-held start in FIXUP SHALL NOT restart the unit.
REQ-024 mthi and mtlo in IDLE SHALL write a to HI or LO at the same edge, with no stall and no state change.
REQ-025 op none or reserved SHALL cause no state change.
REQ-026 hi and lo SHALL hold their values throughout CALC and FIXUP until the FIXUP-exit edge.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, hi = 0, lo = 0, stall = 0, done = 0, and clear all latched operands and the accumulator.
REQ-028 Reset asserted mid-CALC or mid-FIXUP SHALL abandon the operation with no partial HI/LO update.

Structure
REQ-029 Op codes (MD_NONE..MD_MTLO), state encoding, and the width constant 32 SHALL live in the shared muldiv package/include used by the control unit and this block.
REQ-030 The per-cycle add/subtract-and-shift datapath SHALL be a single sub-module muldiv_step, combinational, with one instance shared by multiply and divide.

Verification
REQ-031 multu a = 0xFFFFFFFF, b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; stall high exactly 33 cycles; done high exactly 1 cycle.
REQ-032 mult a = 0xFFFFFFFD (-3), b = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; div a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-033 divu a = 100, b = 0 -> LO = 0xFFFFFFFF, HI = 0x00000064; div a = 0x80000000, b = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-034 mthi a = 0x12345678, then next cycle mtlo a = 0x9ABCDEF0 -> HI and LO visible one cycle after each write; stall stays 0.
REQ-035 Start mult, assert rst_n low at CALC counter 10 -> state IDLE, HI = LO = 0, stall = 0; a following divu 9/4 -> LO = 2, HI = 1.
REQ-036 start held high through FIXUP with op = mult -> exactly one operation executes; op = none with start high -> stall = 0 and HI/LO unchanged.
